// File: rtl/posit_add_scheduler.sv
// Round-robin share of one posit adder across NREQ requesters; accept-to-res_valid is 1+LATENCY cycles.
// One op in flight per requester; a held result blocks that requester's next request until consumed.
module posit_add_scheduler #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 1,
  parameter int NBITS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_in1,
  input  logic [NREQ*NBITS-1:0] req_in2,
  output logic [NREQ-1:0]       res_valid,
  input  logic [NREQ-1:0]       res_ready,
  output logic [NREQ*NBITS-1:0] res_data,
  output logic [NREQ-1:0]       res_inf,
  output logic [NREQ-1:0]       res_zero,
  output logic [NBITS-1:0]      add_in1,
  output logic [NBITS-1:0]      add_in2,
  output logic                  add_start,
  input  logic [NBITS-1:0]      add_result,
  input  logic                  add_inf,
  input  logic                  add_zero,
  input  logic                  add_done,
  output logic                  busy,
  output logic                  err
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    RESULT   = 2'd2
  } req_state_t;

  req_state_t     state_q [NREQ];
  req_state_t     state_d [NREQ];
  logic [IDW-1:0] rr_ptr;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   cand;
  logic [IDW-1:0] idx;
  logic [LATENCY-1:0] tag_vld;
  logic [IDW-1:0] tag_id [LATENCY];
  logic           tail_vld;
  logic [IDW-1:0] tail_id;

  assign tail_vld  = tag_vld[LATENCY-1];
  assign tail_id   = tag_id[LATENCY-1];
  assign req_ready = grant;

  always_comb begin
    eligible  = '0;
    res_valid = '0;
    busy      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i]  = rst_n & req_valid[i] & (state_q[i] == IDLE);
      res_valid[i] = (state_q[i] == RESULT);
      busy         = busy | (state_q[i] != IDLE);
    end
  end

  // Scan from rr_ptr with wrap; first eligible requester wins.
  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    idx     = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(j);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      idx = cand[IDW-1:0];
      if (!gnt_vld && eligible[idx]) begin
        gnt_vld    = 1'b1;
        gnt_id     = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE:     if (grant[i]) state_d[i] = INFLIGHT;
        INFLIGHT: if (tail_vld && tail_id == IDW'(i)) state_d[i] = add_done ? RESULT : IDLE;
        RESULT:   if (res_ready[i]) state_d[i] = IDLE;
        default:  state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) state_q[i] <= IDLE;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) state_q[i] <= state_d[i];
      if (gnt_vld) rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Operands hold when idle so the adder inputs do not toggle needlessly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_start <= 1'b0;
      add_in1   <= '0;
      add_in2   <= '0;
    end else begin
      add_start <= gnt_vld;
      if (gnt_vld) begin
        add_in1 <= req_in1[gnt_id*NBITS +: NBITS];
        add_in2 <= req_in2[gnt_id*NBITS +: NBITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int s = 0; s < LATENCY; s++) tag_id[s] <= '0;
    end else begin
      tag_vld[0] <= gnt_vld;
      tag_id[0]  <= gnt_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  // A done without a live tag (or the reverse) is a sticky protocol error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
      res_inf  <= '0;
      res_zero <= '0;
      err      <= 1'b0;
    end else begin
      if (tail_vld && add_done) begin
        res_data[tail_id*NBITS +: NBITS] <= add_result;
        res_inf[tail_id]                 <= add_inf;
        res_zero[tail_id]                <= add_zero;
      end
      if (tail_vld != add_done) err <= 1'b1;
    end
  end

endmodule
